// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: accepts an operand over valid/ready, shifts up to
// STEP bits per cycle, then holds result and carry/overflow/zero flags until taken.
module seq_shifter #(
  parameter int W    = 64,
  parameter int STEP = 1,
  localparam int AW  = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic          fill,
  input  logic [W-1:0]  operand,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic          carry,
  output logic          ovf,
  output logic          zero,
  output logic [1:0]    state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holds valid and its payload steady until that edge.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] STEP_V = AW'(STEP);

  state_t        state;
  logic [W-1:0]  sreg;
  logic [AW-1:0] rem;
  logic [2:0]    mode_q;
  logic          fill_q;
  logic          sign0;
  logic          carry_w;
  logic          ovf_w;

  logic [AW-1:0] k;
  logic [W-1:0]  nreg;
  logic          ncarry;
  logic          novf;

  assign in_ready  = (state == IDLE);
  assign state_dbg = state;

  // One multi-bit step is built from k single-bit steps so carry and overflow
  // fall out of the last/every bit that leaves the register.
  always_comb begin
    k      = (rem > STEP_V) ? STEP_V : rem;
    nreg   = sreg;
    ncarry = carry_w;
    novf   = ovf_w;
    for (int i = 0; i < STEP; i++) begin
      if (AW'(i) < k) begin
        case (mode_q)
          3'b000, 3'b010: begin ncarry = nreg[W-1]; nreg = {nreg[W-2:0], 1'b0};      end
          3'b001:         begin ncarry = nreg[0];   nreg = {1'b0, nreg[W-1:1]};      end
          3'b011:         begin ncarry = nreg[0];   nreg = {nreg[W-1], nreg[W-1:1]}; end
          3'b100:         begin ncarry = nreg[W-1]; nreg = {nreg[W-2:0], nreg[W-1]}; end
          3'b101:         begin ncarry = nreg[0];   nreg = {nreg[0], nreg[W-1:1]};   end
          3'b110:         begin ncarry = nreg[W-1]; nreg = {nreg[W-2:0], fill_q};    end
          default:        begin ncarry = nreg[0];   nreg = {fill_q, nreg[W-1:1]};    end
        endcase
        if (mode_q == 3'b010 && (ncarry != sign0 || nreg[W-1] != sign0)) novf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      sreg      <= '0;
      rem       <= '0;
      mode_q    <= '0;
      fill_q    <= 1'b0;
      sign0     <= 1'b0;
      carry_w   <= 1'b0;
      ovf_w     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= operand;
            mode_q  <= mode;
            rem     <= amt;
            fill_q  <= fill;
            sign0   <= operand[W-1];
            carry_w <= 1'b0;
            ovf_w   <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sreg    <= nreg;
          rem     <= rem - k;
          carry_w <= ncarry;
          ovf_w   <= novf;
          // rem==k covers both the final partial step and amt==0 (k==0, nreg==sreg).
          if (rem == k) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= nreg;
            carry     <= ncarry;
            ovf       <= novf;
            zero      <= (nreg == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=4) driven with directed and
// random requests, checked by a queue-based scoreboard against an arithmetic model.
module tb_seq_shifter;
  localparam int W = 64;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         z;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         in_valid [2];
  logic         in_ready [2];
  logic [2:0]   mode     [2];
  logic [5:0]   amt      [2];
  logic         fill     [2];
  logic [W-1:0] operand  [2];
  logic         out_valid[2];
  logic         out_ready[2];
  logic [W-1:0] result   [2];
  logic         carry    [2];
  logic         ovf      [2];
  logic         zero     [2];
  logic [1:0]   state_dbg[2];

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  logic holding[2];
  int   rmode[2];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shifter #(.W(W), .STEP(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .mode(mode[0]), .amt(amt[0]), .fill(fill[0]), .operand(operand[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
    .carry(carry[0]), .ovf(ovf[0]), .zero(zero[0]), .state_dbg(state_dbg[0])
  );

  seq_shifter #(.W(W), .STEP(4)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .mode(mode[1]), .amt(amt[1]), .fill(fill[1]), .operand(operand[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
    .carry(carry[1]), .ovf(ovf[1]), .zero(zero[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [2:0] m, input int a, input logic f,
                                 input logic [W-1:0] op, input int step);
    exp_t e;
    logic [W-1:0] r, lo, hi;
    logic signed [W-1:0] s;
    lo = (a == 0) ? '0 : ((64'd1 << a) - 64'd1);
    hi = ~(64'hFFFF_FFFF_FFFF_FFFF >> a);
    case (m)
      3'd0, 3'd2: r = op << a;
      3'd1:       r = op >> a;
      3'd3:       begin s = op; r = s >>> a; end
      3'd4:       r = (a == 0) ? op : ((op << a) | (op >> (W - a)));
      3'd5:       r = (a == 0) ? op : ((op >> a) | (op << (W - a)));
      3'd6:       r = (op << a) | (f ? lo : '0);
      default:    r = (op >> a) | (f ? hi : '0);
    endcase
    e.c = 1'b0;
    if (a != 0) e.c = m[0] ? op[a-1] : op[W-a];
    s = r;
    e.o   = (m == 3'd2) && ((s >>> a) != $signed(op));
    e.res = r;
    e.z   = (r == '0);
    e.lat = (a == 0) ? 1 : (a + step - 1) / step;
    e.acc = 0;
    return e;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int qsize(input int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int l);
    if (l == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // ---------------- driver ----------------
  task automatic send(input int l, input logic [2:0] m, input logic [5:0] a,
                      input logic f, input logic [W-1:0] op);
    exp_t e;
    int guard;
    @(negedge clk);
    mode[l] = m; amt[l] = a; fill[l] = f; operand[l] = op; in_valid[l] = 1'b1;
    guard = 0;
    while (!in_ready[l] && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[l]) begin
      check($sformatf("L%0d accept_timeout", l), 64'(in_ready[l]), 64'd1);
      in_valid[l] = 1'b0;
    end else begin
      e = model(m, int'(a), f, op, (l == 0) ? 1 : 4);
      e.acc = cyc + 1;
      if (l == 0) q0.push_back(e);
      else q1.push_back(e);
      @(posedge clk);
      #1;
      in_valid[l] = 1'b0;
      mode[l]     = 3'($urandom_range(0, 7));
      amt[l]      = 6'($urandom_range(0, 63));
      operand[l]  = {$urandom, $urandom};
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() != 0 || q1.size() != 0 || holding[0] || holding[1]) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- consumer ready ----------------
  always @(posedge clk) begin
    #1;
    for (int l = 0; l < 2; l++) begin
      case (rmode[l])
        0:       out_ready[l] = 1'b0;
        1:       out_ready[l] = 1'b1;
        default: out_ready[l] = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (!rst_b) begin
        holding[l] = 1'b0;
      end else if (out_valid[l]) begin
        if (!holding[l]) begin
          if (qsize(l) == 0) begin
            check($sformatf("L%0d unexpected_out", l), 64'(out_valid[l]), 64'd0);
            cur[l].res = result[l]; cur[l].c = carry[l]; cur[l].o = ovf[l]; cur[l].z = zero[l];
          end else begin
            cur[l] = qpop(l);
            check($sformatf("L%0d result", l), result[l], cur[l].res);
            check($sformatf("L%0d carry", l), 64'(carry[l]), 64'(cur[l].c));
            check($sformatf("L%0d ovf", l), 64'(ovf[l]), 64'(cur[l].o));
            check($sformatf("L%0d zero", l), 64'(zero[l]), 64'(cur[l].z));
            check($sformatf("L%0d latency", l), 64'(cyc - cur[l].acc), 64'(cur[l].lat));
          end
          holding[l] = 1'b1;
        end else begin
          check($sformatf("L%0d hold_result", l), result[l], cur[l].res);
          check($sformatf("L%0d hold_flags", l), 64'({carry[l], ovf[l], zero[l]}),
                64'({cur[l].c, cur[l].o, cur[l].z}));
        end
        if (out_ready[l]) holding[l] = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] op;
    for (int l = 0; l < 2; l++) begin
      in_valid[l] = 1'b0; mode[l] = '0; amt[l] = '0; fill[l] = 1'b0; operand[l] = '0;
      rmode[l] = 1; holding[l] = 1'b0; out_ready[l] = 1'b0;
    end
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("L%0d rst out_valid", l), 64'(out_valid[l]), 64'd0);
      check($sformatf("L%0d rst in_ready", l), 64'(in_ready[l]), 64'd1);
      check($sformatf("L%0d rst result", l), result[l], 64'd0);
      check($sformatf("L%0d rst flags", l), 64'({carry[l], ovf[l], zero[l]}), 64'd0);
    end
    rst_b = 1'b1;

    // Directed corner cases.
    send(0, 3'b000, 6'd63, 1'b0, 64'h1);
    send(1, 3'b011, 6'd4,  1'b0, 64'h8000_0000_0000_0000);
    send(1, 3'b101, 6'd1,  1'b0, 64'h1);
    send(1, 3'b100, 6'd1,  1'b0, 64'h8000_0000_0000_0000);
    send(1, 3'b010, 6'd1,  1'b0, 64'h4000_0000_0000_0000);
    send(1, 3'b010, 6'd1,  1'b0, 64'h1);
    send(1, 3'b110, 6'd7,  1'b1, 64'h0);
    send(1, 3'b111, 6'd63, 1'b1, 64'h0);
    send(1, 3'b001, 6'd63, 1'b0, 64'h1);
    send(1, 3'b010, 6'd5,  1'b0, 64'hFC00_0000_0000_0000);
    drain();

    // Zero-amount request held by a stalled consumer with a queued follower.
    rmode[1] = 0;
    @(negedge clk);
    send(1, 3'b001, 6'd0, 1'b0, 64'hFFFF);
    fork
      begin
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          check("stall out_valid", 64'(out_valid[1]), 64'd1);
          check("stall in_ready", 64'(in_ready[1]), 64'd0);
        end
        rmode[1] = 1;
      end
      send(1, 3'b100, 6'd8, 1'b0, 64'h0123_4567_89AB_CDEF);
    join
    drain();

    // Reset in the middle of a long shift aborts it.
    send(0, 3'b000, 6'd40, 1'b0, 64'hDEAD_BEEF_0000_0001);
    repeat (10) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid[0]), 64'd0);
    check("abort result", result[0], 64'd0);
    check("abort in_ready", 64'(in_ready[0]), 64'd1);
    q0.delete();
    @(negedge clk);
    rst_b = 1'b1;
    repeat (45) @(negedge clk);
    check("abort no_out_valid", 64'(out_valid[0]), 64'd0);
    send(0, 3'b011, 6'd3, 1'b0, 64'h8000_0000_0000_00F0);
    drain();

    // Randomized traffic on both lanes with a bursty consumer.
    rmode[0] = 2;
    rmode[1] = 2;
    for (int n = 0; n < 30; n++) begin
      for (int l = 0; l < 2; l++) begin
        case ($urandom_range(0, 4))
          0:       op = '0;
          1:       op = '1;
          2:       op = 64'h8000_0000_0000_0000 | 64'($urandom);
          default: op = {$urandom, $urandom};
        endcase
        send(l, 3'($urandom_range(0, 7)), 6'($urandom_range(0, (l == 0) ? 20 : 63)),
             1'($urandom_range(0, 1)), op);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
